// File: rtl/addsub_bist.sv
// ---------------------------------------------------------------------------
// addsub_bist
// Built-in self-test engine for an 8-bit combinational add/subtract unit.
// It applies one directed or pseudo-random operand vector at a time and waits
// SETTLE_CYCLES cycles. It then checks SD/Co/Err against a golden model and
// accumulates an error count and the first failing vector.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin a run (honoured in IDLE, or in DONE once done is up)
//   dut_a, dut_b      registered operands driven to the unit under test
//   dut_sub           registered op select (0 = add, 1 = subtract) -> DUT Ci
//   dut_sd/co/err     result, carry-out and signed overflow from the DUT
//   busy, done, pass  run status; pass is meaningful while done is high
//   err_count         mismatching vectors in the run, saturating at 255
//   fail_a/b/sub/sd   operands, op and DUT result of the first failing vector
// ---------------------------------------------------------------------------
module addsub_bist #(
   parameter int          NUM_VECTORS   = 128,
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter int          SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] dut_a,
   output logic [7:0] dut_b,
   output logic       dut_sub,
   input  logic [7:0] dut_sd,
   input  logic       dut_co,
   input  logic       dut_err,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [7:0] fail_a,
   output logic [7:0] fail_b,
   output logic       fail_sub,
   output logic [7:0] fail_sd
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam int          SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [7:0]  LAST_IDX    = 8'(NUM_VECTORS - 1);

   // One step of the 16-bit Galois LFSR (mask 16'hB400).
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] r;
      r = {1'b0, v[15:1]};
      if (v[0]) begin
         r = r ^ 16'hB400;
      end else begin
         r = r;
      end
      return r;
   endfunction

   // Reference add/subtract: returns {err, co, sd}.
   function automatic logic [9:0] golden(input logic [7:0] a, input logic [7:0] b,
                                         input logic sub);
      logic [7:0] bx;
      logic [8:0] s9;
      logic       ovf;
      bx  = b ^ {8{sub}};
      s9  = {1'b0, a} + {1'b0, bx} + {8'd0, sub};
      ovf = (a[7] == bx[7]) && (s9[7] != a[7]);
      return {ovf, s9[8], s9[7:0]};
   endfunction

   state_t          state_r;
   logic [15:0]     lfsr_r;
   logic [7:0]      vec_idx_r;
   logic [SW-1:0]   settle_cnt_r;

   logic [7:0]      vec_a_s;
   logic [7:0]      vec_b_s;
   logic            vec_sub_s;
   logic [9:0]      exp_s;
   logic            mismatch_s;
   logic            restart_s;

   // Current vector: random from the LFSR, with directed overrides at 0 and 7.
   always_comb begin
      vec_a_s   = lfsr_r[7:0];
      vec_b_s   = lfsr_r[15:8];
      vec_sub_s = lfsr_r[0] ^ lfsr_r[15];
      if (vec_idx_r == 8'd0) begin
         vec_a_s   = 8'h80;
         vec_b_s   = 8'h01;
         vec_sub_s = 1'b1;
      end else if (vec_idx_r == 8'd7) begin
         vec_a_s   = 8'h01;
         vec_b_s   = 8'hFF;
         vec_sub_s = 1'b0;
      end else begin
         vec_a_s   = lfsr_r[7:0];
         vec_b_s   = lfsr_r[15:8];
         vec_sub_s = lfsr_r[0] ^ lfsr_r[15];
      end
   end

   // Golden result and compare; the case inequality makes X/Z a mismatch in simulation.
   always_comb begin
      exp_s      = golden(dut_a, dut_b, dut_sub);
      mismatch_s = ({dut_err, dut_co, dut_sd} !== exp_s) ? 1'b1 : 1'b0;
   end

   // In DONE a restart needs done already up, so done is seen for at least
   // one cycle even when start is held high across a whole run.
   always_comb begin
      if (start && (state_r == S_IDLE)) begin
         restart_s = 1'b1;
      end else if (start && (state_r == S_DONE) && done) begin
         restart_s = 1'b1;
      end else begin
         restart_s = 1'b0;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_IDLE;
         lfsr_r       <= SEED;
         vec_idx_r    <= 8'd0;
         settle_cnt_r <= '0;
         dut_a        <= 8'd0;
         dut_b        <= 8'd0;
         dut_sub      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         err_count    <= 8'd0;
         fail_a       <= 8'd0;
         fail_b       <= 8'd0;
         fail_sub     <= 1'b0;
         fail_sd      <= 8'd0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               busy <= 1'b0;
               if (restart_s) begin
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= 8'd0;
                  fail_a    <= 8'd0;
                  fail_b    <= 8'd0;
                  fail_sub  <= 1'b0;
                  fail_sd   <= 8'd0;
                  vec_idx_r <= 8'd0;
                  lfsr_r    <= SEED;
                  state_r   <= S_LOAD;
               end else if (state_r == S_DONE) begin
                  done <= 1'b1;
                  pass <= (err_count == 8'd0) ? 1'b1 : 1'b0;
               end else begin
                  done <= 1'b0;
               end
            end
            S_LOAD: begin
               dut_a        <= vec_a_s;
               dut_b        <= vec_b_s;
               dut_sub      <= vec_sub_s;
               busy         <= 1'b1;
               settle_cnt_r <= '0;
               state_r      <= S_SETTLE;
            end
            S_SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  state_r <= S_CHECK;
               end else begin
                  settle_cnt_r <= settle_cnt_r + {{(SW-1){1'b0}}, 1'b1};
               end
            end
            S_CHECK: begin
               if (mismatch_s) begin
                  // err_count is still zero only before the first failure of the run.
                  if (err_count == 8'd0) begin
                     fail_a   <= dut_a;
                     fail_b   <= dut_b;
                     fail_sub <= dut_sub;
                     fail_sd  <= dut_sd;
                  end
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
               end
               lfsr_r <= lfsr_step(lfsr_r);
               if (vec_idx_r == LAST_IDX) begin
                  state_r <= S_DONE;
               end else begin
                  vec_idx_r <= vec_idx_r + 8'd1;
                  state_r   <= S_LOAD;
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
